// File: rtl/frog_pkg.sv
// Shared key codes, ride directions and life-cycle states for the frog player controller.
package frog_pkg;

  localparam logic [15:0] KEY_NONE = 16'h0000;
  localparam logic [15:0] KEY_W    = 16'h001A;
  localparam logic [15:0] KEY_A    = 16'h0004;
  localparam logic [15:0] KEY_S    = 16'h0016;
  localparam logic [15:0] KEY_D    = 16'h0007;

  localparam logic [1:0] RIDE_NONE  = 2'b00;
  localparam logic [1:0] RIDE_LEFT  = 2'b01;
  localparam logic [1:0] RIDE_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    ALIVE     = 2'b00,
    DYING     = 2'b01,
    GAME_OVER = 2'b10
  } player_state_t;

  function automatic logic is_hop_key(input logic [15:0] k);
    return (k == KEY_W) || (k == KEY_A) || (k == KEY_S) || (k == KEY_D);
  endfunction

endpackage

// File: rtl/frog_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; rolls from all-9s to all-0s.
module frog_bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic                  inc,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [4*DIGITS-1:0] bcd_next;
  logic                carry;

  // Ripple carry: a digit advances only while every lower digit wraps 9 -> 0.
  always_comb begin
    bcd_next = bcd;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (bcd[4*i +: 4] == 4'd9) begin
          bcd_next[4*i +: 4] = 4'd0;
        end else begin
          bcd_next[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      bcd <= '0;
    end else if (clr) begin
      bcd <= '0;
    end else if (inc) begin
      bcd <= bcd_next;
    end
  end

endmodule

// File: rtl/frog_player_ctrl.sv
// Frog player position, lives, BCD score and ALIVE/DYING/GAME_OVER life cycle, one step per frame.
// Optional FROG_HOLD_REPEAT_EN: a held hop key re-hops every REPEAT_FRAMES frames while ALIVE.
module frog_player_ctrl
  import frog_pkg::*;
#(
  parameter int CW             = 10,
  parameter int X_CENTER       = 320,
  parameter int Y_CENTER       = 362,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 639,
  parameter int Y_MIN          = 137,
  parameter int Y_MAX          = 380,
  parameter int X_STEP         = 10,
  parameter int Y_STEP         = 20,
  parameter int SIZE           = 8,
  parameter int LIVES_INIT     = 3,
  parameter int LIVES_W        = 3,
  parameter int SCORE_DIGITS   = 4,
  parameter int RESPAWN_FRAMES = 30,
  parameter int REPEAT_FRAMES  = 12
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic [15:0]               keycode,
  input  logic                      collision,
  input  logic                      in_water,
  input  logic                      success,
  input  logic [1:0]                ride_dir,
  input  logic [2:0]                ride_speed,
  output logic [CW-1:0]             pos_x,
  output logic [CW-1:0]             pos_y,
  output logic [CW-1:0]             pos_s,
  output logic [LIVES_W-1:0]        lives,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [1:0]                state,
  output logic                      game_over
);

  localparam int TW = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

  localparam logic signed [CW:0] XMIN_S = (CW+1)'(X_MIN);
  localparam logic signed [CW:0] XMAX_S = (CW+1)'(X_MAX);
  localparam logic signed [CW:0] YMIN_S = (CW+1)'(Y_MIN);
  localparam logic signed [CW:0] YMAX_S = (CW+1)'(Y_MAX);
  localparam logic signed [CW:0] XSTP_S = (CW+1)'(X_STEP);
  localparam logic signed [CW:0] YSTP_S = (CW+1)'(Y_STEP);

  player_state_t     st;
  logic [TW-1:0]     timer;
  logic [15:0]       prev_key;

  logic              hop_edge;
  logic              hop_accept;
  logic              move_kill;
  logic              death;
  logic              alive_death;
  logic              score_inc;
  logic              score_clr;
  logic signed [CW:0] x_ext, y_ext, nx, ny, rs;

  assign hop_edge = is_hop_key(keycode) && (keycode != prev_key);

`ifdef FROG_HOLD_REPEAT_EN
  localparam int RW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

  logic [RW-1:0] rep_cnt;
  logic          key_held;
  logic          rep_fire;

  // The edge frame itself counts as frame 0 of the hold; repeats land on multiples of REPEAT_FRAMES.
  assign key_held   = (st == ALIVE) && is_hop_key(keycode) && (keycode == prev_key);
  assign rep_fire   = key_held && (rep_cnt == RW'(REPEAT_FRAMES - 1));
  assign hop_accept = hop_edge || rep_fire;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      rep_cnt <= '0;
    end else if (!key_held || alive_death || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  assign hop_accept = hop_edge;
`endif

  assign x_ext = {1'b0, pos_x};
  assign y_ext = {1'b0, pos_y};
  assign rs    = {{(CW-2){1'b0}}, ride_speed};

  // Candidate position for this frame; a hop suppresses the log ride.
  always_comb begin
    nx = x_ext;
    ny = y_ext;
    if (hop_accept) begin
      case (keycode)
        KEY_W: begin
          ny = y_ext - YSTP_S;
          if (ny < YMIN_S) ny = y_ext;
        end
        KEY_S: begin
          ny = y_ext + YSTP_S;
          if (ny > YMAX_S) ny = y_ext;
        end
        KEY_A:   nx = x_ext - XSTP_S;
        KEY_D:   nx = x_ext + XSTP_S;
        default: ;
      endcase
    end else begin
      case (ride_dir)
        RIDE_LEFT:  nx = x_ext - rs;
        RIDE_RIGHT: nx = x_ext + rs;
        default:    ;
      endcase
    end
  end

  assign move_kill   = (nx < XMIN_S) || (nx > XMAX_S);
  assign death       = collision || in_water || move_kill;
  assign alive_death = (st == ALIVE) && !success && death;
  assign score_inc   = (st == ALIVE) && !success && !death && hop_accept;
  assign score_clr   = (st == GAME_OVER) && hop_edge;

  frog_bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .inc       (score_inc),
    .clr       (score_clr),
    .bcd       (score_bcd)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      st       <= ALIVE;
      pos_x    <= CW'(X_CENTER);
      pos_y    <= CW'(Y_CENTER);
      lives    <= LIVES_W'(LIVES_INIT);
      timer    <= '0;
      prev_key <= KEY_NONE;
    end else begin
      prev_key <= keycode;
      case (st)
        ALIVE: begin
          if (success) begin
            pos_x <= CW'(X_CENTER);
            pos_y <= CW'(Y_CENTER);
            lives <= LIVES_W'(LIVES_INIT);
          end else if (death) begin
            pos_x <= CW'(X_CENTER);
            pos_y <= CW'(Y_CENTER);
            if (lives == LIVES_W'(1)) begin
              lives <= '0;
              st    <= GAME_OVER;
            end else begin
              lives <= lives - LIVES_W'(1);
              st    <= DYING;
              timer <= TW'(RESPAWN_FRAMES - 1);
            end
          end else begin
            pos_x <= nx[CW-1:0];
            pos_y <= ny[CW-1:0];
          end
        end
        DYING: begin
          pos_x <= CW'(X_CENTER);
          pos_y <= CW'(Y_CENTER);
          if (timer == '0) begin
            st <= ALIVE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GAME_OVER: begin
          // Restart keeps the centred position; the restarting hop does not move the frog.
          if (hop_edge) begin
            lives <= LIVES_W'(LIVES_INIT);
            st    <= ALIVE;
          end
        end
        default: st <= ALIVE;
      endcase
    end
  end

  assign state     = st;
  assign game_over = (st == GAME_OVER);
  assign pos_s     = CW'(SIZE);

endmodule

// File: tb/tb_frog_player_ctrl.sv
// Directed bench for frog_player_ctrl: reset, hops and clamps, deaths, respawn, game over, score wrap.
module tb_frog_player_ctrl;
  import frog_pkg::*;

  localparam int RESPAWN_FRAMES = 30;

  if (RESPAWN_FRAMES == 0) begin : g_bad_respawn
    initial $fatal(1, "RESPAWN_FRAMES must be nonzero");
  end

  logic        frame_clk;
  logic        Reset;
  logic [15:0] keycode;
  logic        collision, in_water, success;
  logic [1:0]  ride_dir;
  logic [2:0]  ride_speed;
  logic [9:0]  pos_x, pos_y, pos_s;
  logic [2:0]  lives;
  logic [15:0] score_bcd;
  logic [1:0]  state;
  logic        game_over;

  int checks = 0;
  int errors = 0;
  int exp_score = 0;

  frog_player_ctrl #(.RESPAWN_FRAMES(RESPAWN_FRAMES)) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .collision  (collision),
    .in_water   (in_water),
    .success    (success),
    .ride_dir   (ride_dir),
    .ride_speed (ride_speed),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .pos_s      (pos_s),
    .lives      (lives),
    .score_bcd  (score_bcd),
    .state      (state),
    .game_over  (game_over)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic logic [15:0] to_bcd(input int v);
    int r;
    r = v % 10000;
    return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; keycode = KEY_NONE; collision = 0; in_water = 0; success = 0;
    ride_dir = RIDE_NONE; ride_speed = 3'd0;
    repeat (2) tick();
    checks++;
    if (pos_x !== 10'd320 || pos_y !== 10'd362 || lives !== 3'd3 || score_bcd !== 16'h0000 ||
        state !== 2'b00 || game_over !== 1'b0 || pos_s !== 10'd8) begin
      errors++;
      $display("FAIL reset: x=%0d y=%0d lives=%0d score=%h state=%0d go=%b s=%0d, want 320 362 3 0000 0 0 8",
               pos_x, pos_y, lives, score_bcd, state, game_over, pos_s);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_hop_edge();
    keycode = KEY_W;
    tick();
    exp_score++;
    checks++;
    if (pos_y !== 10'd342 || score_bcd !== to_bcd(exp_score)) begin
      errors++; $display("FAIL hop_w: y=%0d score=%h, want 342 %h", pos_y, score_bcd, to_bcd(exp_score));
    end
    repeat (4) tick();
    checks++;
    if (pos_y !== 10'd342 || score_bcd !== to_bcd(exp_score)) begin
      errors++; $display("FAIL hop_held: y=%0d score=%h, want 342 %h", pos_y, score_bcd, to_bcd(exp_score));
    end
    keycode = KEY_NONE; tick();
  endtask

  task automatic test_clamp();
    keycode = KEY_S; tick(); exp_score++;
    checks++;
    if (pos_y !== 10'd362 || score_bcd !== to_bcd(exp_score)) begin
      errors++; $display("FAIL hop_s: y=%0d score=%h, want 362 %h", pos_y, score_bcd, to_bcd(exp_score));
    end
    keycode = KEY_NONE; tick();
    keycode = KEY_S; tick(); exp_score++;
    checks++;
    if (pos_y !== 10'd362 || score_bcd !== to_bcd(exp_score)) begin
      errors++; $display("FAIL clamp_s: y=%0d score=%h, want 362 %h", pos_y, score_bcd, to_bcd(exp_score));
    end
    keycode = KEY_NONE; tick();
    // 11 hops reach 142; the 12th would land at 122 < 137 and holds.
    for (int i = 0; i < 12; i++) begin
      keycode = KEY_W; tick(); exp_score++;
      keycode = KEY_NONE; tick();
    end
    checks++;
    if (pos_y !== 10'd142 || score_bcd !== to_bcd(exp_score)) begin
      errors++; $display("FAIL clamp_w: y=%0d score=%h, want 142 %h", pos_y, score_bcd, to_bcd(exp_score));
    end
    for (int i = 0; i < 11; i++) begin
      keycode = KEY_S; tick(); exp_score++;
      keycode = KEY_NONE; tick();
    end
    checks++;
    if (pos_y !== 10'd362) begin
      errors++; $display("FAIL return_y: y=%0d, want 362", pos_y);
    end
  endtask

  task automatic test_collision();
    collision = 1'b1; tick(); collision = 1'b0;
    checks++;
    if (pos_x !== 10'd320 || pos_y !== 10'd362 || lives !== 3'd2 || state !== 2'b01) begin
      errors++; $display("FAIL collide: x=%0d y=%0d lives=%0d state=%0d, want 320 362 2 1", pos_x, pos_y, lives, state);
    end
    for (int i = 0; i < 29; i++) begin
      keycode = (i % 2 == 0) ? KEY_D : KEY_NONE;
      tick();
    end
    checks++;
    if (state !== 2'b01 || pos_x !== 10'd320 || score_bcd !== to_bcd(exp_score)) begin
      errors++; $display("FAIL dying_hold: state=%0d x=%0d score=%h, want 1 320 %h", state, pos_x, score_bcd, to_bcd(exp_score));
    end
    keycode = KEY_NONE; tick();
    checks++;
    if (state !== 2'b00 || lives !== 3'd2) begin
      errors++; $display("FAIL respawn: state=%0d lives=%0d, want 0 2", state, lives);
    end
  endtask

  task automatic test_kills_and_restart();
    for (int i = 0; i < 31; i++) begin
      keycode = KEY_A; tick(); exp_score++;
      keycode = KEY_NONE; tick();
    end
    ride_dir = RIDE_LEFT; ride_speed = 3'd4;
    repeat (2) tick();
    checks++;
    if (pos_x !== 10'd2 || score_bcd !== to_bcd(exp_score)) begin
      errors++; $display("FAIL ride_left: x=%0d score=%h, want 2 %h", pos_x, score_bcd, to_bcd(exp_score));
    end
    tick();
    ride_dir = RIDE_NONE;
    checks++;
    if (pos_x !== 10'd320 || lives !== 3'd1 || state !== 2'b01) begin
      errors++; $display("FAIL ride_kill: x=%0d lives=%0d state=%0d, want 320 1 1", pos_x, lives, state);
    end
    repeat (RESPAWN_FRAMES) tick();
    for (int i = 0; i < 31; i++) begin
      keycode = KEY_D; tick(); exp_score++;
      keycode = KEY_NONE; tick();
    end
    checks++;
    if (pos_x !== 10'd630 || state !== 2'b00) begin
      errors++; $display("FAIL walk_right: x=%0d state=%0d, want 630 0", pos_x, state);
    end
    keycode = KEY_D; tick();
    checks++;
    if (lives !== 3'd0 || game_over !== 1'b1 || state !== 2'b10 || pos_x !== 10'd320 ||
        score_bcd !== to_bcd(exp_score)) begin
      errors++; $display("FAIL hop_kill_over: lives=%0d go=%b state=%0d x=%0d score=%h, want 0 1 2 320 %h",
                         lives, game_over, state, pos_x, score_bcd, to_bcd(exp_score));
    end
    keycode = KEY_NONE; tick();
    keycode = KEY_D; tick();
    exp_score = 0;
    checks++;
    if (lives !== 3'd3 || score_bcd !== 16'h0000 || state !== 2'b00 || pos_x !== 10'd320 || game_over !== 1'b0) begin
      errors++; $display("FAIL restart: lives=%0d score=%h state=%0d x=%0d go=%b, want 3 0000 0 320 0",
                         lives, score_bcd, state, pos_x, game_over);
    end
    keycode = KEY_NONE; tick();
  endtask

  task automatic test_score_wrap_success();
    for (int i = 0; i < 9999; i++) begin
      keycode = (i % 2 == 0) ? KEY_W : KEY_S;
      tick();
    end
    checks++;
    if (score_bcd !== 16'h9999) begin
      errors++; $display("FAIL score_9999: score=%h, want 9999", score_bcd);
    end
    keycode = KEY_S; tick();
    checks++;
    if (score_bcd !== 16'h0000) begin
      errors++; $display("FAIL score_wrap: score=%h, want 0000", score_bcd);
    end
    exp_score = 0;
    keycode = KEY_NONE; tick();
    in_water = 1'b1; tick(); in_water = 1'b0;
    checks++;
    if (lives !== 3'd2 || state !== 2'b01) begin
      errors++; $display("FAIL water: lives=%0d state=%0d, want 2 1", lives, state);
    end
    repeat (RESPAWN_FRAMES) tick();
    keycode = KEY_A; tick(); exp_score++;
    keycode = KEY_NONE;
    checks++;
    if (pos_x !== 10'd310 || state !== 2'b00) begin
      errors++; $display("FAIL post_water_hop: x=%0d state=%0d, want 310 0", pos_x, state);
    end
    success = 1'b1; collision = 1'b1; tick(); success = 1'b0; collision = 1'b0;
    checks++;
    if (pos_x !== 10'd320 || pos_y !== 10'd362 || lives !== 3'd3 || state !== 2'b00 ||
        score_bcd !== to_bcd(exp_score)) begin
      errors++; $display("FAIL success_collide: x=%0d y=%0d lives=%0d state=%0d score=%h, want 320 362 3 0 %h",
                         pos_x, pos_y, lives, state, score_bcd, to_bcd(exp_score));
    end
  endtask

  task automatic test_hold();
    int exp_x;
    keycode = KEY_NONE; tick();
    keycode = KEY_D;
    repeat (25) tick();
    keycode = KEY_NONE;
`ifdef FROG_HOLD_REPEAT_EN
    exp_x = 350; exp_score += 3;
`else
    exp_x = 330; exp_score += 1;
`endif
    checks++;
    if (pos_x !== 10'(exp_x) || score_bcd !== to_bcd(exp_score)) begin
      errors++; $display("FAIL hold_d: x=%0d score=%h, want %0d %h", pos_x, score_bcd, exp_x, to_bcd(exp_score));
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_hop_edge();
    test_clamp();
    test_collision();
    test_kills_and_restart();
    test_score_wrap_success();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frog_player_ctrl.md
Name: frog_player_ctrl

Overview:
Parametrised successor of the frog player controller. It owns the player position, the lives counter and a multi-digit BCD score, and runs a 3-state life cycle (ALIVE / DYING / GAME_OVER) with a timed respawn. It sits between the keyboard keycode register and the sprite/HUD renderers, and advances once per frame_clk (~60 Hz). It consumes collision, in_water, success and log-ride inputs from the lane logic.

Parameters:
CW, 10, coordinate width in bits
X_CENTER, 320, respawn X
Y_CENTER, 362, respawn Y
X_MIN, 0, leftmost legal X (inclusive)
X_MAX, 639, rightmost legal X (inclusive)
Y_MIN, 137, topmost legal Y (inclusive)
Y_MAX, 380, bottommost legal Y (inclusive)
X_STEP, 10, hop distance on X
Y_STEP, 20, hop distance on Y
SIZE, 8, sprite half-size, driven on pos_s
LIVES_INIT, 3, lives at start, after success, and after restart
LIVES_W, 3, width of the lives counter
SCORE_DIGITS, 4, number of BCD score digits
RESPAWN_FRAMES, 30, frames spent in DYING
REPEAT_FRAMES, 12, hold-to-repeat period (used only by the optional feature)

Ports:
frame_clk  in  1  frame clock
Reset  in  1  asynchronous, active-high
keycode  in  16  current key; W=0x001A, A=0x0004, S=0x0016, D=0x0007, 0x0000=none
collision  in  1  hit by car this frame
in_water  in  1  in river and not on a log this frame
success  in  1  reached home row
ride_dir  in  2  00 none, 01 left, 10 right, 11 none
ride_speed  in  3  pixels per frame while riding
pos_x  out  CW  player X
pos_y  out  CW  player Y
pos_s  out  CW  constant SIZE
lives  out  LIVES_W  remaining lives
score_bcd  out  4*SCORE_DIGITS  score; digit 0 is in the LSBs
state  out  2  00 ALIVE, 01 DYING, 10 GAME_OVER
game_over  out  1  state==GAME_OVER

Behaviour:
- Reset (async): pos=(X_CENTER,Y_CENTER), lives=LIVES_INIT, score=0, state=ALIVE, respawn timer=0, prev_key=0. All outputs are registered, so latency is 1 frame.
- Hop edge: a hop is accepted only when keycode is one of W/A/S/D and differs from prev_key. prev_key<=keycode every frame, in every state.
- ALIVE, evaluated in priority order each frame:
  1. success: pos<=center, lives<=LIVES_INIT, score unchanged.
  2. death (collision | in_water | bounds kill): see DYING entry.
  3. accepted hop:
     - Next position is computed in CW+1-bit signed arithmetic.
     - W: y-Y_STEP; if the result < Y_MIN, y holds.
     - S: y+Y_STEP; if the result > Y_MAX, y holds.
     - A/D: x∓X_STEP; if the result < X_MIN or > X_MAX, this is a bounds kill (death) this frame.
     - Every accepted hop increments score by 1, including a clamped W/S and excluding a kill.
     - ride_dir is ignored in a hop frame.
  4. else ride: x∓ride_speed; the same out-of-range rule gives a bounds kill.
- Score: BCD ripple carry, each digit 0–9. Wrap from all-9s to all-0s.
- DYING entry:
  - pos<=center; lives<=lives-1.
  - If the old lives==1: lives<=0 and state<=GAME_OVER.
  - Otherwise state<=DYING and timer<=RESPAWN_FRAMES-1.
- DYING:
  - All inputs are ignored, but prev_key still tracks keycode.
  - Timer decrements once per frame; at timer==0, state<=ALIVE.
  - Position is held at center.
- GAME_OVER: holds pos, lives=0 and score. An accepted hop edge restarts: lives<=LIVES_INIT, score<=0, state<=ALIVE, pos stays at center, and the hop itself is not applied.
- Simultaneous events: success beats collision/in_water. Death beats a hop.
- RESPAWN_FRAMES=0 is illegal; the bench asserts this at elaboration.

Optional Feature:
FROG_HOLD_REPEAT_EN
- Defined: while the same hop key stays held in ALIVE, a repeat counter is kept. Every REPEAT_FRAMES frames the held key generates an accepted hop, with identical movement and score rules. The counter clears on key change, on death, and in non-ALIVE states.
- Undefined: only the edge rule applies, and no repeat counter is synthesised.

Decomposition:
- Package frog_pkg:
  - key constants KEY_W / KEY_A / KEY_S / KEY_D / KEY_NONE
  - enum player_state_t {ALIVE, DYING, GAME_OVER}
  - ride_dir constants
- Sub-module frog_bcd_counter, parametrised by DIGITS:
  - inputs inc and clr
  - output bcd
  - async Reset
  - wraps from all-9s to all-0s

Test Plan:
- Reset, then keycode 0x0000→0x001A held 5 frames → pos_y 362→342 once; score_bcd=0x0001.
- pos_y=362, press S (0x0016) → y holds 362 (362+20>380); score_bcd=0x0002 after a prior hop.
- ALIVE, lives=3, collision=1 for 1 frame → next frame pos=(320,362), lives=2, state=DYING; 30 frames later state=ALIVE; hops ignored during DYING.
- ride_dir=01, ride_speed=4, pos_x=2 → next frame bounds kill, lives decrements; lives=1 on kill → lives=0, game_over=1; then a D edge → lives=3, score=0, state=ALIVE, pos_x=320.
- score preset via 9999 hops (SCORE_DIGITS=4) → next hop gives score_bcd=0x0000; success together with collision → pos center, lives=3, no decrement.
- With FROG_HOLD_REPEAT_EN defined: hold D for 25 frames → 3 hops (frames 0, 12, 24), pos_x=350; without the macro → 1 hop, pos_x=330.
